// File: rtl/md_pkg.sv
// md_pkg: shared constants for the iterative multiply/divide unit.
//   - MD_ITER          : iterations per operation (equals operand width)
//   - MD_MULT..MD_DIVU : i_op encodings
//   - MD_S_*           : sequencer state encodings
//   - md_mag()         : operand magnitude (absolute value when signed)
package md_pkg;

    localparam int MD_ITER = 32;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    localparam logic [1:0] MD_S_IDLE = 2'd0;
    localparam logic [1:0] MD_S_CALC = 2'd1;
    localparam logic [1:0] MD_S_FIX  = 2'd2;

    function automatic logic [31:0] md_mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_shift_core.sv
// md_shift_core: 64-bit shift/add/subtract datapath, one step per enabled cycle.
// Build option: MD_DIV_EN adds the restoring-divide step; without it only
// multiply steps exist and div_mode is ignored.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   load              load acc = {0, load_a} and operand register = load_b
//   step              perform one iteration
//   div_mode          1 = divide step, 0 = multiply step
//   load_a, load_b    operand magnitudes
//   acc               accumulator (mul: product; div: {remainder, quotient})
module md_shift_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic        div_mode,
    input  logic [31:0] load_a,
    input  logic [31:0] load_b,
    output logic [63:0] acc
);
    logic [31:0] opb;
    logic [32:0] sum;
    logic [63:0] acc_next;
`ifdef MD_DIV_EN
    logic [32:0] rem;
    logic [32:0] diff;
`else
    logic        unused_mode;
    assign unused_mode = div_mode;
`endif

    always_comb begin
        // Multiply: add multiplier to the upper half when the LSB is set,
        // then shift right keeping the carry.
        sum      = {1'b0, acc[63:32]} + {1'b0, opb};
        acc_next = acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]};
`ifdef MD_DIV_EN
        // Restoring divide: shift the next dividend bit into the remainder
        // and keep the difference only when it does not go negative.
        rem  = {acc[63:32], acc[31]};
        diff = rem - {1'b0, opb};
        if (div_mode) begin
            acc_next = diff[32] ? {rem[31:0], acc[30:0], 1'b0}
                                : {diff[31:0], acc[30:0], 1'b1};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 64'd0;
            opb <= 32'd0;
        end else if (load) begin
            acc <= {32'd0, load_a};
            opb <= load_b;
        end else if (step) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: multiply/divide controller owning HI/LO.
// Build option: MD_DIV_EN enables DIV/DIVU; without it a division start
// pulses o_unsupported and o_div_zero is tied low.
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset
//   i_start, i_op            launch request and operation (MULT/MULTU/DIV/DIVU)
//   i_op_a, i_op_b           operands
//   i_mthi, i_mtlo, i_wdata  HI/LO writes (IDLE only)
//   i_rd_hilo                MFHI/MFLO in execute (stalls while busy)
//   i_flush                  abort the operation in flight
//   o_hi, o_lo               architectural HI/LO
//   o_busy, o_stall          status / hazard stall
//   o_done, o_div_zero       completion pulse, divide-by-zero flag
//   o_unsupported            division requested while compiled out
module md_sequencer
    import md_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    input  logic        i_mthi,
    input  logic        i_mtlo,
    input  logic [31:0] i_wdata,
    input  logic        i_rd_hilo,
    input  logic        i_flush,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_busy,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_div_zero,
    output logic        o_unsupported
);
    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] hi_q, lo_q;
    logic        div_op, res_neg, unsup_q;
    logic        launch, accept, is_signed;
    logic [31:0] a_mag, b_mag;
    logic [63:0] acc, prod;
    logic [31:0] res_hi, res_lo;
`ifdef MD_DIV_EN
    logic        rem_neg, dz_q;
`endif

    assign is_signed = ~i_op[0];
    assign a_mag     = md_mag(i_op_a, is_signed);
    assign b_mag     = md_mag(i_op_b, is_signed);
    assign launch    = (state == MD_S_IDLE) & i_start & ~i_flush;
`ifdef MD_DIV_EN
    assign accept     = launch;
    assign o_div_zero = o_done & dz_q;
`else
    assign accept     = launch & ~i_op[1];
    assign o_div_zero = 1'b0;
`endif

    assign o_hi          = hi_q;
    assign o_lo          = lo_q;
    assign o_busy        = (state != MD_S_IDLE);
    assign o_stall       = o_busy & (i_start | i_rd_hilo | i_mthi | i_mtlo);
    assign o_done        = (state == MD_S_FIX) & ~i_flush;
    assign o_unsupported = unsup_q;

    md_shift_core u_core (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (accept),
        .step     (state == MD_S_CALC),
        .div_mode (div_op),
        .load_a   (a_mag),
        .load_b   (b_mag),
        .acc      (acc)
    );

    // Sign fix-up: product negated as a whole, quotient/remainder separately.
    always_comb begin
        prod   = res_neg ? (~acc + 64'd1) : acc;
        res_hi = prod[63:32];
        res_lo = prod[31:0];
`ifdef MD_DIV_EN
        if (div_op) begin
            res_hi = rem_neg ? (~acc[63:32] + 32'd1) : acc[63:32];
            // Divide by zero leaves the all-ones quotient un-negated.
            res_lo = (res_neg & ~dz_q) ? (~acc[31:0] + 32'd1) : acc[31:0];
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= MD_S_IDLE;
            cnt     <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            div_op  <= 1'b0;
            res_neg <= 1'b0;
            unsup_q <= 1'b0;
`ifdef MD_DIV_EN
            rem_neg <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            unsup_q <= 1'b0;
            case (state)
                MD_S_IDLE: begin
                    if (i_mthi) hi_q <= i_wdata;
                    if (i_mtlo) lo_q <= i_wdata;
                    if (accept) begin
                        state   <= MD_S_CALC;
                        cnt     <= 5'd0;
                        div_op  <= i_op[1];
                        res_neg <= is_signed & (i_op_a[31] ^ i_op_b[31]);
`ifdef MD_DIV_EN
                        rem_neg <= is_signed & i_op_a[31];
                        dz_q    <= i_op[1] & (i_op_b == 32'd0);
`endif
                    end
`ifndef MD_DIV_EN
                    unsup_q <= launch & i_op[1];
`endif
                end
                MD_S_CALC: begin
                    if (i_flush) begin
                        state <= MD_S_IDLE;
                    end else begin
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'(MD_ITER - 1)) state <= MD_S_FIX;
                    end
                end
                MD_S_FIX: begin
                    state <= MD_S_IDLE;
                    if (!i_flush) begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
                end
                default: state <= MD_S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;
    import md_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_start, i_mthi, i_mtlo, i_rd_hilo, i_flush;
    logic [1:0]  i_op;
    logic [31:0] i_op_a, i_op_b, i_wdata;
    logic [31:0] o_hi, o_lo;
    logic        o_busy, o_stall, o_done, o_div_zero, o_unsupported;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dz;
    } vec_t;
    vec_t vecs[$];

    md_sequencer dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op),
        .i_op_a(i_op_a), .i_op_b(i_op_b), .i_mthi(i_mthi), .i_mtlo(i_mtlo),
        .i_wdata(i_wdata), .i_rd_hilo(i_rd_hilo), .i_flush(i_flush),
        .o_hi(o_hi), .o_lo(o_lo), .o_busy(o_busy), .o_stall(o_stall),
        .o_done(o_done), .o_div_zero(o_div_zero), .o_unsupported(o_unsupported)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // first IDLE cycle after FIX (k=33), so back-to-back starts are exercised.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output logic dz,
                          output int done_at, output int done_cnt, output int busy_cnt);
        i_start = 1'b1; i_op = op; i_op_a = a; i_op_b = b;
        done_at = -1; done_cnt = 0; busy_cnt = 0; dz = 1'b0;
        for (int k = 0; k <= 33; k++) begin
            @(negedge i_clk);
            if (k == 0) i_start = 1'b0;
            #1;
            if (o_busy) busy_cnt++;
            if (o_done) begin done_cnt++; done_at = k; end
            if (o_div_zero) dz = 1'b1;
        end
        hi = o_hi; lo = o_lo;
    endtask

    initial begin
        logic [31:0] hi, lo;
        logic        dz, seen;
        int          done_at, done_cnt, busy_cnt, stall_bad;

        i_rst_n = 1'b0; i_start = 1'b0; i_op = 2'd0; i_op_a = '0; i_op_b = '0;
        i_mthi = 1'b0; i_mtlo = 1'b0; i_wdata = '0; i_rd_hilo = 1'b0; i_flush = 1'b0;

        vecs.push_back('{MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0});
        vecs.push_back('{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0});
        vecs.push_back('{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0});
        vecs.push_back('{MD_MULT,  32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0});
        vecs.push_back('{MD_MULT,  32'd0,        32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0});
        vecs.push_back('{MD_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0});
`ifdef MD_DIV_EN
        vecs.push_back('{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
        vecs.push_back('{MD_DIVU,  32'h64,       32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1});
        vecs.push_back('{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0});
        vecs.push_back('{MD_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1});
        vecs.push_back('{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0});
`endif

        // Reset state
        repeat (2) @(negedge i_clk);
        chk("rst hi", o_hi, 32'd0);
        chk("rst lo", o_lo, 32'd0);
        chk("rst busy", {31'd0, o_busy}, 32'd0);
        chk("rst done", {31'd0, o_done}, 32'd0);
        chk("rst stall", {31'd0, o_stall}, 32'd0);
        chk("rst dz", {31'd0, o_div_zero}, 32'd0);
        chk("rst unsup", {31'd0, o_unsupported}, 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Table-driven operations, issued back to back
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, dz, done_at, done_cnt, busy_cnt);
            chk($sformatf("vec%0d hi", i), hi, vecs[i].hi);
            chk($sformatf("vec%0d lo", i), lo, vecs[i].lo);
            chk($sformatf("vec%0d div_zero", i), {31'd0, dz}, {31'd0, vecs[i].dz});
            chk($sformatf("vec%0d done_cycle", i), done_at, 32'd32);
            chk($sformatf("vec%0d done_count", i), done_cnt, 32'd1);
            chk($sformatf("vec%0d busy_cycles", i), busy_cnt, 32'd33);
        end

        // MTHI/MTLO in IDLE, then a MULT flushed in CALC cycle 10
        @(negedge i_clk);
        i_mthi = 1'b1; i_wdata = 32'h0000A5A5;
        @(negedge i_clk);
        i_mthi = 1'b0; i_mtlo = 1'b1; i_wdata = 32'h00001234;
        @(negedge i_clk);
        i_mtlo = 1'b0;
        chk("mthi hi", o_hi, 32'h0000A5A5);
        chk("mtlo lo", o_lo, 32'h00001234);
        i_start = 1'b1; i_op = MD_MULT; i_op_a = 32'd7; i_op_b = 32'd9;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (10) @(negedge i_clk);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        chk("flush busy", {31'd0, o_busy}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge i_clk);
            seen |= o_done;
        end
        chk("flush no done", {31'd0, seen}, 32'd0);
        chk("flush hi", o_hi, 32'h0000A5A5);
        chk("flush lo", o_lo, 32'h00001234);

        // MFHI/MFLO stall during CALC/FIX; second start while busy ignored
        i_start = 1'b1; i_op = MD_MULTU; i_op_a = 32'd3; i_op_b = 32'd4;
        @(negedge i_clk);
        #1;
        chk("stall start busy", {31'd0, o_stall}, 32'd1);
        i_start = 1'b0;
        stall_bad = 0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge i_clk);
            if (k == 3) i_rd_hilo = 1'b1;
            if (k == 5) i_start = 1'b1;
            if (k == 8) i_start = 1'b0;
            #1;
            if (k >= 3 && k <= 32 && !o_stall) stall_bad++;
            if (k == 32) chk("stall fix done", {31'd0, o_done}, 32'd1);
            if (k == 33) chk("stall after fix", {31'd0, o_stall}, 32'd0);
        end
        i_rd_hilo = 1'b0;
        chk("stall cycles low", stall_bad, 32'd0);
        chk("second start ignored", {31'd0, o_busy}, 32'd0);
        chk("stall op hi", o_hi, 32'd0);
        chk("stall op lo", o_lo, 32'd12);

        // MTHI and start in the same IDLE cycle: both take effect
        i_mthi = 1'b1; i_wdata = 32'h0000BEEF;
        i_start = 1'b1; i_op = MD_MULT; i_op_a = 32'd2; i_op_b = 32'd3;
        @(negedge i_clk);
        i_mthi = 1'b0; i_start = 1'b0;
        chk("mthi+start hi", o_hi, 32'h0000BEEF);
        chk("mthi+start busy", {31'd0, o_busy}, 32'd1);
        repeat (33) @(negedge i_clk);
        chk("mthi+start res hi", o_hi, 32'd0);
        chk("mthi+start res lo", o_lo, 32'd6);

        // Flush during FIX suppresses done and the HI/LO write
        i_start = 1'b1; i_op = MD_MULT; i_op_a = 32'd5; i_op_b = 32'd5;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (32) @(negedge i_clk);
        chk("fix done pre-flush", {31'd0, o_done}, 32'd1);
        i_flush = 1'b1;
        #1;
        chk("fix flush done", {31'd0, o_done}, 32'd0);
        @(negedge i_clk);
        i_flush = 1'b0;
        chk("fix flush hi", o_hi, 32'd0);
        chk("fix flush lo", o_lo, 32'd6);
        chk("fix flush busy", {31'd0, o_busy}, 32'd0);

`ifndef MD_DIV_EN
        // Division compiled out
        i_start = 1'b1; i_op = MD_DIVU; i_op_a = 32'd100; i_op_b = 32'd7;
        @(negedge i_clk);
        i_start = 1'b0;
        chk("unsup pulse", {31'd0, o_unsupported}, 32'd1);
        chk("unsup busy", {31'd0, o_busy}, 32'd0);
        @(negedge i_clk);
        chk("unsup pulse end", {31'd0, o_unsupported}, 32'd0);
        chk("unsup busy2", {31'd0, o_busy}, 32'd0);
        chk("unsup hi", o_hi, 32'd0);
        chk("unsup lo", o_lo, 32'd6);
`endif

        // Asynchronous reset mid-operation
        i_start = 1'b1; i_op = MD_MULT; i_op_a = 32'hFFFFFFFF; i_op_b = 32'hFFFFFFFF;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (5) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk("async rst busy", {31'd0, o_busy}, 32'd0);
        chk("async rst lo", o_lo, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("post rst busy", {31'd0, o_busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Iterative multiply/divide controller for the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU from the execute stage and sequences a shared 64-bit shift/add/subtract datapath over 32 iterations. It owns the architectural HI/LO registers, services MTHI/MTLO/MFHI/MFLO, and raises a stall to the hazard logic while a result is pending.

## Interface
- `MD_ITER`, 32: iteration count; equals the operand width.
- `i_clk`  in  1  rising-edge clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_start`  in  1  launch request; sampled only in IDLE.
- `i_op`  in  2  operation select: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- `i_op_a`, `i_op_b`  in  32  multiplicand/dividend and multiplier/divisor.
- `i_mthi`, `i_mtlo`  in  1  write `i_wdata` to HI or LO.
- `i_wdata`  in  32  MTHI/MTLO data.
- `i_rd_hilo`  in  1  MFHI/MFLO in execute.
- `i_flush`  in  1  pipeline flush or exception; aborts the operation in flight.
- `o_hi`, `o_lo`  out  32  architectural HI/LO.
- `o_busy`  out  1  operation in progress.
- `o_stall`  out  1  `o_busy & (i_start | i_rd_hilo | i_mthi | i_mtlo)`.
- `o_done`  out  1  one-cycle pulse in FIX.
- `o_div_zero`  out  1  pulses with `o_done` when a DIV/DIVU divisor is 0.
- `o_unsupported`  out  1  one-cycle pulse when a division is started with division compiled out.

## Operation
- Reset values: HI=LO=0; state IDLE; all pulse and status outputs 0.
- States and transitions:
  - IDLE -> CALC on `i_start & ~i_flush`. On entry, latch the op and the operand magnitudes: absolute values for MULT/DIV, raw values for unsigned ops. Also latch the result signs: product sign is `a[31]^b[31]`; quotient sign is `a[31]^b[31]`; remainder sign is `a[31]`.
  - CALC: runs `MD_ITER` cycles with a 5-bit counter from 0 to 31.
    - Multiply: radix-2 shift-add into the 64-bit accumulator.
    - Divide: restoring shift-subtract. The remainder is kept in acc[63:32] and the quotient in acc[31:0].
  - CALC -> FIX when the counter reaches 31.
  - FIX: apply two's-complement negation to each result whose sign is set, assert `o_done`, write HI/LO, then go to IDLE.
- Result placement:
  - Multiply: HI={product[63:32]}, LO={product[31:0]}.
  - Divide: HI=remainder, LO=quotient.
- Divide by zero: HI=`i_op_a`, LO=32'hFFFFFFFF, `o_div_zero`=1. This is computed in the same 34 cycles; there is no short path.
- Signed overflow: 0x80000000/‑1 gives LO=0x80000000, HI=0, which the algorithm produces naturally.
- MTHI/MTLO are honoured only in IDLE; while busy they are held off by `o_stall`. If MTHI/MTLO and `i_start` arrive in the same IDLE cycle, the write occurs and the operation starts.
- `i_flush` in CALC or FIX returns the state to IDLE at the next edge. HI/LO are unchanged and no `o_done` is issued. A flush coinciding with the FIX edge also suppresses the HI/LO write.
- `i_start` while busy is ignored; the requester is frozen by `o_stall`.

## Timing
- `i_start` is sampled at edge E0.
- CALC occupies the cycles after edges E0..E31.
- FIX occupies the cycle after E32, with `o_done` high in that cycle.
- HI/LO change at E33 and are visible to MFHI/MFLO from the cycle after E33. Total latency is 34 cycles.
- `o_busy` is high from the cycle after E0 through FIX inclusive.
- Back-to-back operations: a new `i_start` is accepted in the first IDLE cycle after FIX.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous).

## Configuration
- `MD_DIV_EN` defined: DIV/DIVU are supported as described above.
- `MD_DIV_EN` undefined:
  - The subtract/restore path and the divide-by-zero logic are removed.
  - `i_start` with `i_op[1]`=1 stays in IDLE, pulses `o_unsupported` for one cycle, and leaves HI/LO unchanged.
  - `o_div_zero` is tied to 0.

## Structure
- Shared package `md_pkg` holds:
  - op encodings `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`;
  - state encodings `MD_S_IDLE`, `MD_S_CALC`, `MD_S_FIX`;
  - `MD_ITER`.
- Sub-module `md_shift_core` contains the 64-bit accumulator plus the operand register and the one-step add/subtract logic. It takes a step enable and a mode input.
- `md_sequencer` keeps the FSM, the counter, sign handling, HI/LO and the stall logic.

## Test plan
- MULT, a=0xFFFFFFFD (‑3), b=5 -> at E33 HI=0xFFFFFFFF, LO=0xFFFFFFF1; `o_done` high exactly in the FIX cycle.
- MULTU, a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV, a=0xFFFFFFF9 (‑7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU, a=0x64, b=0 -> HI=0x64, LO=0xFFFFFFFF, `o_div_zero`=1.
- MTLO 0x1234 in IDLE, then MULT, with `i_flush` at cycle 10 of CALC -> `o_busy` low the next cycle, LO=0x1234, HI unchanged, no `o_done`.
- `i_rd_hilo` asserted during CALC -> `o_stall`=1 every cycle through FIX and 0 the cycle after. A second `i_start` while busy is ignored.
- With `MD_DIV_EN` undefined, DIVU started -> `o_unsupported` pulses once, `o_busy` stays 0, HI/LO are unchanged.
